// File: rtl/dflow_replay_sched.sv
// Replay sequencer for the dflow packet generator: runs the store phase, then
// replays the stored memory window as read commands for a configured number of loops.
module dflow_replay_sched #(
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int LOOP_WIDTH     = 16,
  parameter int GAP_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sw_rst,
  input  logic                      cal_done,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [LOOP_WIDTH-1:0]     cfg_loop_count,
  input  logic [GAP_WIDTH-1:0]      cfg_gap,
  input  logic [MEM_ADDR_WIDTH-1:0] dflow_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0] dflow_addr_high,
  input  logic                      store_done,
  input  logic [MEM_ADDR_WIDTH-1:0] dflow_mem_high,
  output logic                      start_store,
  output logic                      app_rd_cmd,
  output logic [MEM_ADDR_WIDTH-1:0] app_rd_addr,
  input  logic                      app_rd_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic [LOOP_WIDTH-1:0]     loops_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_STORE,
    S_REPLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [LOOP_WIDTH-1:0]     loop_cfg_q, loop_cfg_d;
  logic [GAP_WIDTH-1:0]      gap_cfg_q, gap_cfg_d;
  logic [MEM_ADDR_WIDTH-1:0] low_q, low_d;
  logic [MEM_ADDR_WIDTH-1:0] rd_last_q, rd_last_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [GAP_WIDTH-1:0]      gap_cnt_q, gap_cnt_d;
  logic [LOOP_WIDTH-1:0]     loops_q, loops_d;
  logic                      start_store_q, start_store_d;
  logic                      rd_cmd_q, rd_cmd_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      xfer;
  logic                      at_last;
  logic                      win_small;
  logic [LOOP_WIDTH-1:0]     loops_inc;
  logic                      loop_limit_hit;

  assign xfer           = rd_cmd_q & app_rd_ready;
  // Treat any address at or past rd_last as the loop end so a wrapped window cannot run away.
  assign at_last        = (addr_q >= rd_last_q);
  assign win_small      = ({1'b0, dflow_addr_high} <=
                           ({1'b0, dflow_addr_low} + (MEM_ADDR_WIDTH+1)'(1)));
  assign loops_inc      = loops_q + LOOP_WIDTH'(1);
  assign loop_limit_hit = (loop_cfg_q != '0) && (loops_inc == loop_cfg_q);

  always_comb begin
    state_d       = state_q;
    loop_cfg_d    = loop_cfg_q;
    gap_cfg_d     = gap_cfg_q;
    low_d         = low_q;
    rd_last_d     = rd_last_q;
    addr_d        = addr_q;
    gap_cnt_d     = gap_cnt_q;
    loops_d       = loops_q;
    err_d         = err_q;
    start_store_d = 1'b0;
    rd_cmd_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          loop_cfg_d = cfg_loop_count;
          gap_cfg_d  = cfg_gap;
          low_d      = dflow_addr_low;
          loops_d    = '0;
          err_d      = 1'b0;
          addr_d     = '0;
          if (win_small) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cal_done) begin
            state_d       = S_STORE;
            start_store_d = 1'b1;
          end else begin
            state_d = S_WAIT_CAL;
          end
        end
      end

      S_WAIT_CAL: begin
        if (cal_done) begin
          state_d       = S_STORE;
          start_store_d = 1'b1;
        end
      end

      S_STORE: begin
        if (cfg_stop) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else if (store_done) begin
          rd_last_d = dflow_mem_high - MEM_ADDR_WIDTH'(1);
          addr_d    = low_q;
          state_d   = S_REPLAY;
          rd_cmd_d  = cal_done;
        end else begin
          start_store_d = 1'b1;
        end
      end

      S_REPLAY: begin
        // A transfer coinciding with stop still counts toward the loop total.
        if (xfer && at_last) begin
          loops_d = loops_inc;
        end
        if (cfg_stop) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else if (xfer && at_last) begin
          if (loop_limit_hit) begin
            state_d = S_DONE;
            addr_d  = '0;
          end else if (gap_cfg_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cfg_q;
          end else begin
            addr_d   = low_q;
            rd_cmd_d = cal_done;
          end
        end else begin
          if (xfer) begin
            addr_d = addr_q + MEM_ADDR_WIDTH'(1);
          end
          rd_cmd_d = cal_done;
        end
      end

      S_GAP: begin
        if (cfg_stop) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d  = S_REPLAY;
          addr_d   = low_q;
          rd_cmd_d = cal_done;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || sw_rst) begin
      state_q       <= S_IDLE;
      loop_cfg_q    <= '0;
      gap_cfg_q     <= '0;
      low_q         <= '0;
      rd_last_q     <= '0;
      addr_q        <= '0;
      gap_cnt_q     <= '0;
      loops_q       <= '0;
      start_store_q <= 1'b0;
      rd_cmd_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      loop_cfg_q    <= loop_cfg_d;
      gap_cfg_q     <= gap_cfg_d;
      low_q         <= low_d;
      rd_last_q     <= rd_last_d;
      addr_q        <= addr_d;
      gap_cnt_q     <= gap_cnt_d;
      loops_q       <= loops_d;
      start_store_q <= start_store_d;
      rd_cmd_q      <= rd_cmd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign start_store = start_store_q;
  assign app_rd_cmd  = rd_cmd_q;
  assign app_rd_addr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = err_q;
  assign loops_done  = loops_q;

endmodule

// File: doc/dflow_replay_sched.md
# dflow_replay_sched

Sequencer for the dflow packet generator's external memory. It runs the store phase by driving the 5-tuple writer's `start_store` until the writer reports completion. It then issues read commands over the stored address window, from low address to last written address, for a configured number of loops with an optional idle gap between loops. It sits between the host/config registers and the memory read port, beside the FIFO-to-memory writer.

## Interface
- `MEM_ADDR_WIDTH`, 19, memory word address width
- `LOOP_WIDTH`, 16, loop count / loop counter width
- `GAP_WIDTH`, 8, inter-loop gap counter width

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `sw_rst` in 1: software reset, synchronous, active-high, identical effect to `rst`
- `cal_done` in 1: memory calibration complete
- `cfg_start` in 1: one-cycle start pulse
- `cfg_stop` in 1: one-cycle stop pulse
- `cfg_loop_count` in LOOP_WIDTH: replay loops; 0 = run until `cfg_stop`
- `cfg_gap` in GAP_WIDTH: idle cycles between loops
- `dflow_addr_low` in MEM_ADDR_WIDTH: window start
- `dflow_addr_high` in MEM_ADDR_WIDTH: window end (exclusive bound for the writer)
- `store_done` in 1: writer completion flag (level)
- `dflow_mem_high` in MEM_ADDR_WIDTH: writer's current write pointer
- `start_store` out 1: enables the writer
- `app_rd_cmd` out 1: read request (valid)
- `app_rd_addr` out MEM_ADDR_WIDTH: read address
- `app_rd_ready` in 1: memory accepts read this cycle
- `busy` out 1: state not IDLE and not DONE
- `done` out 1: state DONE
- `cfg_err` out 1: window too small at start
- `loops_done` out LOOP_WIDTH: completed replay loops

## Operation
- States: IDLE, WAIT_CAL, STORE, REPLAY, GAP, DONE. All outputs are registered.
- Reset (`rst` or `sw_rst`), any state: the block enters IDLE. All outputs are 0 and `app_rd_addr` is 0. This also applies mid-operation.
- IDLE or DONE plus `cfg_start`:
  - Latch `cfg_loop_count`, `cfg_gap`, `dflow_addr_low`, `dflow_addr_high`.
  - Clear `loops_done` and `cfg_err`.
  - If `dflow_addr_high` ≤ `dflow_addr_low`+1 (unsigned): set `cfg_err` and go to DONE.
  - Else go to STORE if `cal_done`, otherwise WAIT_CAL.
- WAIT_CAL: go to STORE when `cal_done`=1.
- STORE: `start_store`=1.
  - When `store_done`=1: latch `rd_last` = `dflow_mem_high`−1 (MEM_ADDR_WIDTH wrap), set `app_rd_addr` = latched low, go to REPLAY with `start_store`=0.
  - A `cal_done` drop does not change state.
- REPLAY: `app_rd_cmd`=1 while `cal_done`=1. If `cal_done` is 0, `app_rd_cmd`=0 and the address holds.
  - A transfer is `app_rd_cmd`∧`app_rd_ready`. The address is held stable until the transfer.
  - On a transfer at addr < `rd_last`: addr+1.
  - On a transfer at `rd_last`: `loops_done`+1 (wraps), then:
    - if `cfg_loop_count`≠0 and the new `loops_done` = `cfg_loop_count`: DONE;
    - else if `cfg_gap`≠0: GAP with `app_rd_cmd`=0;
    - else addr = low and REPLAY continues back-to-back.
- GAP: idle exactly `cfg_gap` cycles with `app_rd_cmd`=0, then REPLAY with addr = low.
- `cfg_stop` in STORE, REPLAY or GAP: next state DONE, with `start_store` and `app_rd_cmd` 0.
  - A transfer in the same cycle as `cfg_stop` is counted, including its loop increment.
  - Stop takes priority over the loop-end transition.
- `cfg_stop` in IDLE or DONE has no effect. `cfg_start` while busy is ignored.
- DONE: `done`=1; outputs other than `done`, `cfg_err` and `loops_done` are 0.

## Timing
- `cfg_start` at cycle N in IDLE with `cal_done`=1: `start_store`=1 from N+1.
- `store_done` sampled 1 at cycle M: `start_store`=0 and `app_rd_cmd`=1 at M+1.
- Back-to-back reads: one address per cycle while `app_rd_ready`=1.
- Loop-end transfer at cycle K with gap G>0: `app_rd_cmd`=0 for K+1..K+G; next read of low at K+G+1.
- Final transfer at K: `done`=1 and `app_rd_cmd`=0 at K+1.
- `cfg_stop` at S: `done`=1 at S+1.

## Test plan
- low=0x10, high=0x14, loop_count=2, gap=0, ready=1, writer model completes with mem_high=0x13 → reads 0x10,0x11,0x12,0x10,0x11,0x12; `loops_done`=2; `done`=1 the cycle after the last read.
- Same window, gap=3 → exactly 3 idle cycles between 0x12 and the next 0x10.
- `app_rd_ready` toggled 1,0,0,1 → address held while ready is low; no skipped or duplicated addresses.
- loop_count=0, `cfg_stop` asserted in the same cycle as the transfer of `rd_last` on loop 5 → `loops_done`=5, DONE next cycle.
- low=0x20, high=0x21 → `cfg_err`=1, `done`=1, `start_store` never asserted.
- `cal_done`=0 at start → WAIT_CAL, `start_store`=0; `cal_done` rises → `start_store`=1 next cycle; `sw_rst` mid-REPLAY → IDLE with all outputs 0 the next cycle.
